exception_pc_ctrl: RTL and testbench
====================================

# exception_pc_ctrl

Sequencer that drives the next-PC selector of the multicycle datapath. It turns the control unit's PC-update requests and the datapath's exception flags into the 3-bit PC source code, the PC write enable and the EPC write enable. It also runs the multi-cycle exception entry: save EPC, read the handler-vector byte from memory, load PC from memory data. It sits between the main control FSM and the PC/EPC registers and the next-PC selector.

## Interface
Parameters:
- VEC_INVALID, 253, memory byte address holding the invalid-opcode handler address
- VEC_OVF, 254, vector address for arithmetic overflow
- VEC_DIV0, 255, vector address for divide by zero
- MEM_WAIT, 1, memory read wait cycles after the address cycle (legal 0..3)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock, no other clock domains
- req_seq  in  1  sequential update (PC := ALU result, PC+4)
- req_jump  in  1  jump (PC := jump address)
- req_branch  in  1  branch request
- branch_cond  in  1  branch condition; qualifies req_branch
- req_rte  in  1  return from exception (PC := EPC)
- op_invalid  in  1  invalid opcode flag
- overflow  in  1  ALU overflow flag
- div_zero  in  1  divide-by-zero flag
- pc_source  out  3  next-PC select code: 0 jump address, 1 ALU result, 2 ALUOut, 3 memory data, 4 EPC
- pc_write  out  1  PC load enable
- epc_write  out  1  EPC load enable (the EPC input is the faulting instruction address, PC-4, formed outside this block)
- vec_addr  out  32  memory address for the vector fetch; 0 when not fetching
- vec_read  out  1  memory read strobe for the vector fetch; also steers the memory address mux
- exc_cause  out  2  0 none, 1 invalid opcode, 2 overflow, 3 divide by zero
- busy  out  1  high in any state other than IDLE

## Operation
States: IDLE, EXC_ADDR, EXC_WAIT, EXC_LOAD.
- IDLE: outputs are combinational from the inputs.
  - Exception priority: op_invalid > overflow > div_zero.
  - When any exception flag is set: epc_write=1, pc_write=0, exc_cause is registered with the winning code, vec_addr is latched to the matching vector, next state EXC_ADDR. All requests in the same cycle are ignored.
  - Otherwise, requests are taken in priority order req_rte > req_jump > req_branch&branch_cond > req_seq. They give pc_source 4/0/2/1 respectively, with pc_write=1.
  - A taken req_rte also clears exc_cause to 0.
  - req_branch with branch_cond=0 and no other request: pc_write=0.
- EXC_ADDR: vec_read=1, drive vec_addr. If MEM_WAIT=0, next state is EXC_LOAD; otherwise load the wait counter with MEM_WAIT-1 and go to EXC_WAIT.
- EXC_WAIT: vec_read=1. Decrement the counter; leave for EXC_LOAD when the counter is 0.
- EXC_LOAD: pc_source=3, pc_write=1, vec_read=0, next state IDLE. The memory data path supplies the zero-extended vector byte.
- Outside IDLE, all request and exception inputs are ignored; they are not queued.
- Default when not writing: pc_source=1, pc_write=0, epc_write=0.
- Wait counter is 2 bits wide.

## Timing
- Reset values: state IDLE, pc_source=1, pc_write=0, epc_write=0, vec_read=0, vec_addr=0, exc_cause=0, busy=0, wait counter 0.
- Reset asserted mid-exception: abort immediately to IDLE with reset values. No PC load occurs.
- Normal requests: zero latency. pc_write is asserted in the request cycle and PC updates on that edge.
- Exception entry: EPC is written on the detection edge; PC is loaded on the edge ending EXC_LOAD.
  - Total time from detection to PC load is MEM_WAIT+3 cycles (detection, EXC_ADDR, MEM_WAIT wait cycles, EXC_LOAD).
  - busy is high for MEM_WAIT+2 cycles.
- Exception flag coincident with req_rte: the exception wins, and exc_cause takes the new code.
- A new exception while busy is dropped. The control FSM is responsible for holding off while busy.

## Structure
- Shared package: the pc_source encodings (PCS_JUMP=0, PCS_RESULT=1, PCS_ALUOUT=2, PCS_MEM=3, PCS_EPC=4), the exc_cause codes, the state enum, and the default vector addresses.
- Single module. No sub-module is required. The wait counter stays inline.

## Test plan
- Reset asserted, then released with no requests -> pc_write=0, pc_source=1, busy=0, exc_cause=0.
- req_seq alone -> same cycle pc_source=1, pc_write=1. Then req_jump and req_branch asserted together with branch_cond=1 -> pc_source=0. Then req_branch with branch_cond=0 -> pc_write=0.
- overflow and div_zero pulsed together, MEM_WAIT=1 -> epc_write=1 in cycle 0, exc_cause=2. vec_addr=254 with vec_read=1 in cycles 1-2. pc_source=3 with pc_write=1 in cycle 3. busy low in cycle 4.
- op_invalid with MEM_WAIT=0 -> vec_addr=253 and PC load in cycle 2. req_seq pulsed during the exception is ignored (no extra pc_write).
- After an exception, req_rte -> pc_source=4, pc_write=1, exc_cause returns to 0 on the next cycle.
- reset pulsed in EXC_WAIT with MEM_WAIT=3 -> state IDLE, no pc_write, vec_read=0, exc_cause=0.

Source files
------------

// File: rtl/exception_pc_ctrl_pkg.sv
// Shared encodings for the exception/PC sequencer: next-PC select codes,
// exception cause codes, sequencer states and the default vector addresses.
package exception_pc_ctrl_pkg;

    localparam logic [2:0] PCS_JUMP   = 3'd0;
    localparam logic [2:0] PCS_RESULT = 3'd1;
    localparam logic [2:0] PCS_ALUOUT = 3'd2;
    localparam logic [2:0] PCS_MEM    = 3'd3;
    localparam logic [2:0] PCS_EPC    = 3'd4;

    localparam logic [31:0] VEC_INVALID_DEF = 32'd253;
    localparam logic [31:0] VEC_OVF_DEF     = 32'd254;
    localparam logic [31:0] VEC_DIV0_DEF    = 32'd255;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_INVALID = 2'd1,
        CAUSE_OVF     = 2'd2,
        CAUSE_DIV0    = 2'd3
    } exc_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXC_ADDR = 2'd1,
        ST_EXC_WAIT = 2'd2,
        ST_EXC_LOAD = 2'd3
    } state_e;

    // Invalid opcode outranks overflow, which outranks divide by zero.
    function automatic exc_cause_e exc_priority(input logic op_invalid,
                                                input logic overflow,
                                                input logic div_zero);
        exc_cause_e cause;
        cause = CAUSE_NONE;
        if (op_invalid) begin
            cause = CAUSE_INVALID;
        end else if (overflow) begin
            cause = CAUSE_OVF;
        end else if (div_zero) begin
            cause = CAUSE_DIV0;
        end
        return cause;
    endfunction

endpackage

// File: rtl/exception_pc_ctrl.sv
// Next-PC sequencer: zero-latency PC-update requests from the control FSM, and
// a multi-cycle exception entry (save EPC, fetch handler vector byte, load PC).
module exception_pc_ctrl
    import exception_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_INVALID = VEC_INVALID_DEF,
    parameter logic [31:0] VEC_OVF     = VEC_OVF_DEF,
    parameter logic [31:0] VEC_DIV0    = VEC_DIV0_DEF,
    parameter int unsigned MEM_WAIT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_seq,
    input  logic        req_jump,
    input  logic        req_branch,
    input  logic        branch_cond,
    input  logic        req_rte,
    input  logic        op_invalid,
    input  logic        overflow,
    input  logic        div_zero,
    output logic [2:0]  pc_source,
    output logic        pc_write,
    output logic        epc_write,
    output logic [31:0] vec_addr,
    output logic        vec_read,
    output logic [1:0]  exc_cause,
    output logic        busy
);

    localparam logic [1:0] WAIT_LOAD = (MEM_WAIT == 0) ? 2'd0 : 2'(MEM_WAIT - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [1:0]  r_wait_cnt;
    logic [1:0]  w_wait_cnt_nxt;
    exc_cause_e  r_exc_cause;
    exc_cause_e  w_exc_cause_nxt;
    logic [31:0] r_vec_addr;
    logic [31:0] w_vec_addr_nxt;
    exc_cause_e  w_new_cause;

    assign w_new_cause = exc_priority(op_invalid, overflow, div_zero);

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_exc_cause_nxt = r_exc_cause;
        w_vec_addr_nxt  = r_vec_addr;
        pc_source       = PCS_RESULT;
        pc_write        = 1'b0;
        epc_write       = 1'b0;
        vec_read        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // An exception swallows every request raised in the same cycle.
                if (w_new_cause != CAUSE_NONE) begin
                    epc_write       = 1'b1;
                    w_exc_cause_nxt = w_new_cause;
                    w_state_nxt     = ST_EXC_ADDR;
                    case (w_new_cause)
                        CAUSE_INVALID: w_vec_addr_nxt = VEC_INVALID;
                        CAUSE_OVF:     w_vec_addr_nxt = VEC_OVF;
                        default:       w_vec_addr_nxt = VEC_DIV0;
                    endcase
                end else if (req_rte) begin
                    pc_source       = PCS_EPC;
                    pc_write        = 1'b1;
                    w_exc_cause_nxt = CAUSE_NONE;
                end else if (req_jump) begin
                    pc_source = PCS_JUMP;
                    pc_write  = 1'b1;
                end else if (req_branch && branch_cond) begin
                    pc_source = PCS_ALUOUT;
                    pc_write  = 1'b1;
                end else if (req_seq) begin
                    pc_source = PCS_RESULT;
                    pc_write  = 1'b1;
                end
            end
            ST_EXC_ADDR: begin
                vec_read = 1'b1;
                if (MEM_WAIT == 0) begin
                    w_state_nxt = ST_EXC_LOAD;
                end else begin
                    w_wait_cnt_nxt = WAIT_LOAD;
                    w_state_nxt    = ST_EXC_WAIT;
                end
            end
            ST_EXC_WAIT: begin
                vec_read = 1'b1;
                if (r_wait_cnt == 2'd0) begin
                    w_state_nxt = ST_EXC_LOAD;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 2'd1;
                end
            end
            ST_EXC_LOAD: begin
                pc_source   = PCS_MEM;
                pc_write    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 2'd0;
            r_exc_cause <= CAUSE_NONE;
            r_vec_addr  <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_exc_cause <= w_exc_cause_nxt;
            r_vec_addr  <= w_vec_addr_nxt;
        end
    end

    // The vector address is only presented while the fetch strobe is up.
    assign vec_addr  = vec_read ? r_vec_addr : 32'd0;
    assign exc_cause = r_exc_cause;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_exception_pc_ctrl.sv
// Bench for exception_pc_ctrl: three instances (MEM_WAIT 0, 1, 3) share the
// stimulus; each scenario scores the instance it targets, cycle by cycle.
module tb_exception_pc_ctrl;

    typedef logic [7:0] stim_t;
    typedef struct packed {
        logic [2:0]  ps;
        logic        pw;
        logic        ew;
        logic        vr;
        logic [31:0] va;
        logic        busy;
        logic [1:0]  cause;
    } out_t;

    // Stimulus bits: seq, jump, branch, cond, rte, invalid, overflow, div0
    localparam stim_t NON = 8'h00;
    localparam stim_t SEQ = 8'h80;
    localparam stim_t JMP = 8'h40;
    localparam stim_t BR  = 8'h20;
    localparam stim_t CND = 8'h10;
    localparam stim_t RTE = 8'h08;
    localparam stim_t INV = 8'h04;
    localparam stim_t OVF = 8'h02;
    localparam stim_t DIV = 8'h01;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_seq, req_jump, req_branch, branch_cond, req_rte;
    logic op_invalid, overflow, div_zero;

    logic [2:0]  pcs  [3];
    logic        pcw  [3];
    logic        epcw [3];
    logic [31:0] vad  [3];
    logic        vrd  [3];
    logic [1:0]  cse  [3];
    logic        bsy  [3];

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t sb[$];

    always #5 clk = ~clk;

    exception_pc_ctrl #(.MEM_WAIT(0)) u_mw0 (
        .clk(clk), .reset(reset), .req_seq(req_seq), .req_jump(req_jump),
        .req_branch(req_branch), .branch_cond(branch_cond), .req_rte(req_rte),
        .op_invalid(op_invalid), .overflow(overflow), .div_zero(div_zero),
        .pc_source(pcs[0]), .pc_write(pcw[0]), .epc_write(epcw[0]),
        .vec_addr(vad[0]), .vec_read(vrd[0]), .exc_cause(cse[0]), .busy(bsy[0])
    );

    exception_pc_ctrl #(.MEM_WAIT(1)) u_mw1 (
        .clk(clk), .reset(reset), .req_seq(req_seq), .req_jump(req_jump),
        .req_branch(req_branch), .branch_cond(branch_cond), .req_rte(req_rte),
        .op_invalid(op_invalid), .overflow(overflow), .div_zero(div_zero),
        .pc_source(pcs[1]), .pc_write(pcw[1]), .epc_write(epcw[1]),
        .vec_addr(vad[1]), .vec_read(vrd[1]), .exc_cause(cse[1]), .busy(bsy[1])
    );

    exception_pc_ctrl #(.MEM_WAIT(3)) u_mw3 (
        .clk(clk), .reset(reset), .req_seq(req_seq), .req_jump(req_jump),
        .req_branch(req_branch), .branch_cond(branch_cond), .req_rte(req_rte),
        .op_invalid(op_invalid), .overflow(overflow), .div_zero(div_zero),
        .pc_source(pcs[2]), .pc_write(pcw[2]), .epc_write(epcw[2]),
        .vec_addr(vad[2]), .vec_read(vrd[2]), .exc_cause(cse[2]), .busy(bsy[2])
    );

    function automatic out_t mk(input logic [2:0] ps, input logic pw, input logic ew,
                                input logic vr, input logic [31:0] va,
                                input logic b, input logic [1:0] c);
        out_t o;
        o.ps = ps; o.pw = pw; o.ew = ew; o.vr = vr; o.va = va; o.busy = b; o.cause = c;
        return o;
    endfunction

    function automatic out_t observe(input int i);
        return mk(pcs[i], pcw[i], epcw[i], vrd[i], vad[i], bsy[i], cse[i]);
    endfunction

    task automatic drive(input stim_t s);
        {req_seq, req_jump, req_branch, branch_cond, req_rte,
         op_invalid, overflow, div_zero} = s;
    endtask

    task automatic settle();
        int n = 0;
        @(posedge clk); #1;
        drive(NON);
        while ((bsy[0] | bsy[1] | bsy[2]) && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bsy[0] | bsy[1] | bsy[2]) begin
            n_fail++;
            $display("FAIL settle: busy still %b%b%b after %0d cycles, required all low",
                     bsy[0], bsy[1], bsy[2], n);
        end
    endtask

    task automatic test_reset();
        out_t obs, exp;
        drive(NON);
        sb.push_back(mk(3'd1, 0, 0, 0, 32'd0, 0, 2'd0));
        @(negedge clk);
        obs = observe(1); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL reset_held: got %h required %h", obs, exp);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        sb.push_back(mk(3'd1, 0, 0, 0, 32'd0, 0, 2'd0));
        @(negedge clk);
        obs = observe(1); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL reset_released: got %h required %h", obs, exp);
        end
    endtask

    task automatic test_requests();
        stim_t st[8];
        out_t  ex[8];
        out_t  obs, exp;
        st = '{SEQ, JMP | BR | CND, BR, BR | CND, RTE, JMP | SEQ, RTE | JMP, NON};
        ex = '{mk(3'd1, 1, 0, 0, 0, 0, 0), mk(3'd0, 1, 0, 0, 0, 0, 0),
               mk(3'd1, 0, 0, 0, 0, 0, 0), mk(3'd2, 1, 0, 0, 0, 0, 0),
               mk(3'd4, 1, 0, 0, 0, 0, 0), mk(3'd0, 1, 0, 0, 0, 0, 0),
               mk(3'd4, 1, 0, 0, 0, 0, 0), mk(3'd1, 0, 0, 0, 0, 0, 0)};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk);
            obs = observe(1); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL requests[%0d]: got %h required %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_exc_mw1();
        stim_t st[5];
        out_t  ex[5];
        out_t  obs, exp;
        st = '{OVF | DIV, NON, INV, NON, NON};
        ex = '{mk(3'd1, 0, 1, 0, 32'd0,   0, 2'd0), mk(3'd1, 0, 0, 1, 32'd254, 1, 2'd2),
               mk(3'd1, 0, 0, 1, 32'd254, 1, 2'd2), mk(3'd3, 1, 0, 0, 32'd0,   1, 2'd2),
               mk(3'd1, 0, 0, 0, 32'd0,   0, 2'd2)};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk);
            obs = observe(1); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL exc_mw1[%0d]: got %h required %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_rte();
        stim_t st[2];
        out_t  ex[2];
        out_t  obs, exp;
        st = '{RTE, NON};
        ex = '{mk(3'd4, 1, 0, 0, 0, 0, 2'd2), mk(3'd1, 0, 0, 0, 0, 0, 2'd0)};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk);
            obs = observe(1); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL rte[%0d]: got %h required %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_exc_mw0();
        stim_t st[4];
        out_t  ex[4];
        out_t  obs, exp;
        st = '{INV | OVF | RTE, SEQ, SEQ, NON};
        ex = '{mk(3'd1, 0, 1, 0, 32'd0,   0, 2'd0), mk(3'd1, 0, 0, 1, 32'd253, 1, 2'd1),
               mk(3'd3, 1, 0, 0, 32'd0,   1, 2'd1), mk(3'd1, 0, 0, 0, 32'd0,   0, 2'd1)};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk);
            obs = observe(0); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL exc_mw0[%0d]: got %h required %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[7];
        out_t  ex[7];
        out_t  obs, exp;
        st = '{DIV, NON, NON, JMP, SEQ, JMP, NON};
        ex = '{mk(3'd1, 0, 1, 0, 32'd0,   0, 2'd1), mk(3'd1, 0, 0, 1, 32'd255, 1, 2'd3),
               mk(3'd1, 0, 0, 1, 32'd255, 1, 2'd3), mk(3'd3, 1, 0, 0, 32'd0,   1, 2'd3),
               mk(3'd1, 1, 0, 0, 32'd0,   0, 2'd3), mk(3'd0, 1, 0, 0, 32'd0,   0, 2'd3),
               mk(3'd1, 0, 0, 0, 32'd0,   0, 2'd3)};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk);
            obs = observe(1); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL back_to_back[%0d]: got %h required %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_midexc();
        stim_t st[4];
        out_t  ex[4];
        out_t  obs, exp;
        st = '{OVF, NON, NON, NON};
        ex = '{mk(3'd1, 0, 1, 0, 32'd0,   0, 2'd3), mk(3'd1, 0, 0, 1, 32'd254, 1, 2'd2),
               mk(3'd1, 0, 0, 1, 32'd254, 1, 2'd2), mk(3'd1, 0, 0, 1, 32'd254, 1, 2'd2)};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(st[i]); sb.push_back(ex[i]);
            @(negedge clk);
            obs = observe(2); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL reset_midexc[%0d]: got %h required %h", i, obs, exp);
            end
        end
        #2;
        reset = 1'b1;
        sb.push_back(mk(3'd1, 0, 0, 0, 32'd0, 0, 2'd0));
        #1;
        obs = observe(2); exp = sb.pop_front(); n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL reset_abort: got %h required %h", obs, exp);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                @(posedge clk); #1;
                drive(SEQ);
                sb.push_back(mk(3'd1, 1, 0, 0, 32'd0, 0, 2'd0));
            end else begin
                if (i == 1) begin
                    @(posedge clk); #1;
                end
                sb.push_back(mk(3'd1, 0, 0, 0, 32'd0, 0, 2'd0));
            end
            @(negedge clk);
            obs = observe(2); exp = sb.pop_front(); n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL after_reset[%0d]: got %h required %h", i, obs, exp);
            end
        end
    endtask

    initial begin
        drive(NON);
        test_reset();
        test_requests();
        settle();
        test_exc_mw1();
        settle();
        test_rte();
        settle();
        test_exc_mw0();
        settle();
        test_back_to_back();
        settle();
        test_reset_midexc();
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
